// File: rtl/byte_word_port.sv
// Byte-serial word port: assembles LANES host bytes into a loaded word and serialises a stored word onto the host pins.
// Latency: request sampled in IDLE -> one STALL cycle -> LANES data cycles -> one DONE pulse cycle; all outputs registered.
// Backpressure: host_ready low in RX/TX freezes the lane index and holds address_out/data_out stable; core requests wait in IDLE.
//
// Ports:
//   clk, rst (sync, active-low)        - clock and reset
//   data_in, host_ready                - host byte and host flow control
//   rx_req, tx_req, tx_word            - core load/store requests (levels) and store word
//   rx_word, rx_valid, tx_done, busy   - completed load word, completion pulses, activity flag
//   data_out, address_out              - store byte and stall code / byte index to the host
module byte_word_port #(
    parameter int LANE_W    = 8,
    parameter int LANES     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANE_W-1:0]        data_in,
    input  logic                     host_ready,
    input  logic                     rx_req,
    input  logic                     tx_req,
    input  logic [LANES*LANE_W-1:0]  tx_word,
    output logic [LANES*LANE_W-1:0]  rx_word,
    output logic                     rx_valid,
    output logic                     tx_done,
    output logic                     busy,
    output logic [LANE_W-1:0]        data_out,
    output logic [LANE_W-1:0]        address_out
);

    localparam int                WORD_W     = LANES * LANE_W;
    localparam logic [LANE_W-1:0] K_LAST     = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] K_ONE      = LANE_W'(1);
    localparam logic [LANE_W-1:0] TX_FLAG    = {1'b1, {(LANE_W-1){1'b0}}};
    localparam logic [LANE_W-1:0] STALL_CODE = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STALL = 3'd1,
        S_RX    = 3'd2,
        S_TX    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [LANE_W-1:0]   k, k_nxt;
    logic                dir, dir_nxt;        // 0 = RX, 1 = TX
    logic [WORD_W-1:0]   asm_q, asm_nxt;
    logic [WORD_W-1:0]   tx_buf;
    logic [LANE_W-1:0]   addr_nxt, dout_nxt;
    logic                rx_valid_nxt, tx_done_nxt, busy_nxt;

    // Transfer ordinal k -> physical lane within the word.
    function automatic int lane_of(input logic [LANE_W-1:0] idx);
        lane_of = MSB_FIRST ? (LANES - 1 - int'(idx)) : int'(idx);
    endfunction

    // Assembly register with the current host byte merged into its lane.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[lane_of(k)*LANE_W +: LANE_W] = data_in;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dir_nxt   = dir;
        case (state)
            S_IDLE: begin
                k_nxt = '0;
                if (rx_req) begin
                    state_nxt = S_STALL;
                    dir_nxt   = 1'b0;
                end else if (tx_req) begin
                    state_nxt = S_STALL;
                    dir_nxt   = 1'b1;
                end
            end
            S_STALL: begin
                state_nxt = dir ? S_TX : S_RX;
                k_nxt     = '0;
            end
            S_RX, S_TX: begin
                if (host_ready) begin
                    if (k == K_LAST) begin
                        state_nxt = S_DONE;
                        k_nxt     = '0;
                    end else begin
                        k_nxt = k + K_ONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // every port can be driven straight from a flop.
    always_comb begin
        addr_nxt     = '0;
        dout_nxt     = '0;
        rx_valid_nxt = 1'b0;
        tx_done_nxt  = 1'b0;
        busy_nxt     = (state_nxt != S_IDLE);
        case (state_nxt)
            S_STALL: addr_nxt = STALL_CODE;
            S_RX:    addr_nxt = k_nxt + K_ONE;
            S_TX: begin
                addr_nxt = TX_FLAG | (k_nxt + K_ONE);
                dout_nxt = tx_buf[lane_of(k_nxt)*LANE_W +: LANE_W];
            end
            S_DONE: begin
                rx_valid_nxt = ~dir_nxt;
                tx_done_nxt  = dir_nxt;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            k           <= '0;
            dir         <= 1'b0;
            asm_q       <= '0;
            tx_buf      <= '0;
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            tx_done     <= 1'b0;
            busy        <= 1'b0;
            data_out    <= '0;
            address_out <= '0;
        end else begin
            state       <= state_nxt;
            k           <= k_nxt;
            dir         <= dir_nxt;
            rx_valid    <= rx_valid_nxt;
            tx_done     <= tx_done_nxt;
            busy        <= busy_nxt;
            data_out    <= dout_nxt;
            address_out <= addr_nxt;
            // Snapshot the store word on the accepting edge; later changes
            // on tx_word cannot disturb the transfer.
            if (state == S_IDLE && !rx_req && tx_req) begin
                tx_buf <= tx_word;
            end
            if (state == S_RX && host_ready) begin
                asm_q <= asm_nxt;
                // Only a fully assembled word is published.
                if (k == K_LAST) begin
                    rx_word <= asm_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_word_port.sv
module tb_byte_word_port;

    localparam int LW    = 8;
    localparam int LANES = 4;
    localparam int WW    = LW * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LW-1:0] data_in = '0;
    logic          host_ready = 1'b1;
    logic          rx_req = 1'b0;
    logic          tx_req = 1'b0;
    logic [WW-1:0] tx_word = '0;

    logic [WW-1:0] rxw0, rxw1;
    logic          rxv0, rxv1, txd0, txd1, busy0, busy1;
    logic [LW-1:0] d0, d1, a0, a1;

    always #5 clk = ~clk;

    byte_word_port #(.LANE_W(LW), .LANES(LANES), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .host_ready(host_ready),
        .rx_req(rx_req), .tx_req(tx_req), .tx_word(tx_word),
        .rx_word(rxw0), .rx_valid(rxv0), .tx_done(txd0), .busy(busy0),
        .data_out(d0), .address_out(a0)
    );

    byte_word_port #(.LANE_W(LW), .LANES(LANES), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .host_ready(host_ready),
        .rx_req(rx_req), .tx_req(tx_req), .tx_word(tx_word),
        .rx_word(rxw1), .rx_valid(rxv1), .tx_done(txd1), .busy(busy1),
        .data_out(d1), .address_out(a1)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    // A transfer is a script of cycles: one stall beat, LANES data beats
    // (each may be repeated while the host holds off), one done beat.
    typedef struct {
        int kind;   // 0 stall, 1 data, 2 done
        int idx;    // transfer ordinal for data beats
    } beat_t;

    beat_t         q[$];
    bit            m_dir;              // 1 = store
    logic [WW-1:0] m_tx;
    logic [LW-1:0] m_bytes [LANES];
    logic [WW-1:0] m_rxw0 = '0, m_rxw1 = '0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_rxw0 = '0;
            m_rxw1 = '0;
        end else if (q.size() == 0) begin
            if (rx_req || tx_req) begin
                m_dir = !rx_req;
                if (m_dir) m_tx = tx_word;
                q.push_back('{0, 0});
                for (int i = 0; i < LANES; i++) q.push_back('{1, i});
                q.push_back('{2, 0});
            end
        end else if (!(q[0].kind == 1 && !host_ready)) begin
            if (q[0].kind == 1 && !m_dir) begin
                m_bytes[q[0].idx] = data_in;
                if (q[0].idx == LANES - 1) begin
                    for (int i = 0; i < LANES; i++) begin
                        m_rxw0[LW*i +: LW]             = m_bytes[i];
                        m_rxw1[LW*(LANES-1-i) +: LW]   = m_bytes[i];
                    end
                end
            end
            void'(q.pop_front());
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [LW-1:0] ea, ed0, ed1;
        logic          eb, erv, etd;
        if (chk_en) begin
            ea = '0; ed0 = '0; ed1 = '0; eb = 1'b0; erv = 1'b0; etd = 1'b0;
            if (q.size() != 0) begin
                eb = 1'b1;
                if (q[0].kind == 0) begin
                    ea = 8'hFF;
                end else if (q[0].kind == 1) begin
                    ea = (m_dir ? 8'h80 : 8'h00) | LW'(q[0].idx + 1);
                    if (m_dir) begin
                        ed0 = m_tx[LW*q[0].idx +: LW];
                        ed1 = m_tx[LW*(LANES-1-q[0].idx) +: LW];
                    end
                end else begin
                    erv = !m_dir;
                    etd = m_dir;
                end
            end
            chk("addr_lsb", a0, ea);
            chk("addr_msb", a1, ea);
            chk("dout_lsb", d0, ed0);
            chk("dout_msb", d1, ed1);
            chk("busy_lsb", busy0, eb);
            chk("busy_msb", busy1, eb);
            chk("rxv_lsb", rxv0, erv);
            chk("rxv_msb", rxv1, erv);
            chk("txd_lsb", txd0, etd);
            chk("txd_msb", txd1, etd);
            chk("rxw_lsb", rxw0, m_rxw0);
            chk("rxw_msb", rxw1, m_rxw1);
        end
    end

    // ---------------- Directed helpers ----------------
    int lat;
    bit seen;

    // Load one word; byte for index i+1 is word[8i+:8]. While address_out
    // equals hold_at the host stalls hold_len cycles and drives a junk byte.
    task automatic run_rx(input logic [WW-1:0] word, input int hold_at, input int hold_len,
                          output int latency);
        int hl;
        int ai;
        bit got;
        hl = hold_len;
        got = 1'b0;
        latency = 0;
        @(negedge clk);
        rx_req = 1'b1;
        host_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_req = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (rxv0) begin
                got = 1'b1;
            end else begin
                ai = int'(a0);
                if (ai >= 1 && ai <= LANES) begin
                    if (ai == hold_at && hl > 0) begin
                        host_ready = 1'b0;
                        data_in = 8'h55;
                        hl--;
                    end else begin
                        host_ready = 1'b1;
                        data_in = word[LW*(ai-1) +: LW];
                    end
                end
                @(posedge clk);
                latency++;
                @(negedge clk);
            end
        end
        host_ready = 1'b1;
        chk("rx_valid_seen", got, 1);
    endtask

    logic [LW-1:0] sb [LANES];

    initial begin
        sb = '{8'h04, 8'h00, 8'h08, 8'h8D};

        // Reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_addr", a0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_rxword", rxw0, 0);
        rst = 1'b1;

        // Load, both lane orders
        run_rx(32'hDEADBEEF, 0, 0, lat);
        chk("load_latency", lat, LANES + 1);
        chk("load_lsb_word", rxw0, 32'hDEADBEEF);
        chk("load_msb_word", rxw1, 32'hEFBEADDE);

        // Store, tx_word disturbed after acceptance
        @(negedge clk);
        tx_word = 32'h8D080004;
        tx_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_req = 1'b0;
        tx_word = $urandom;
        chk("store_stall", a0, 8'hFF);
        for (int i = 0; i < LANES; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("store_beat", {a0, d0}, {8'h81 + 8'(i), sb[i]});
        end
        @(posedge clk);
        @(negedge clk);
        chk("store_done", txd0, 1);

        // Simultaneous requests: RX first, TX after the IDLE cycle
        @(negedge clk);
        rx_req = 1'b1;
        tx_req = 1'b1;
        tx_word = 32'h12345678;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            data_in = LW'($urandom);
            if (rxv0) seen = 1'b1;
        end
        chk("simul_rx_first", seen, 1);
        rx_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("simul_idle_gap", busy0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("simul_tx_stall", a0, 8'hFF);
        tx_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (txd0) seen = 1'b1;
        end
        chk("simul_tx_done", seen, 1);

        // Flow control: 3-cycle host stall at index 2
        run_rx(32'hDEADBEEF, 2, 3, lat);
        chk("flow_latency", lat, LANES + 4);
        chk("flow_word", rxw0, 32'hDEADBEEF);

        // Reset in the middle of a load
        @(negedge clk);
        rx_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_req = 1'b0;
        for (int n = 0; n < 20 && a0 != 8'h03; n++) begin
            if (a0 >= 8'h01 && a0 <= 8'h04) data_in = LW'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_mid_at_idx3", a0, 8'h03);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", {rxw0, d0, a0, busy0, rxv0, txd0}, 0);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rx_req     = ($urandom % 8) == 0;
            tx_req     = ($urandom % 6) == 0;
            host_ready = ($urandom % 4) != 0;
            data_in    = LW'($urandom);
            tx_word    = $urandom;
            rst        = ($urandom % 300) != 0;
        end
        @(negedge clk);
        rx_req = 1'b0;
        tx_req = 1'b0;
        host_ready = 1'b1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_idle", busy0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
